bus_sram_slave: RTL and testbench

BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

---
 rtl/bus_sram_slave.sv | 158 +++++++++++++++
 tb/tb_bus_sram_slave.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sram_slave.sv
// Word-organised SRAM slave on a request/done bus, with programmable wait states.
// Define BUS_SRAM_SLAVE_BERR_EN to add the berr fault output.
package bus_sram_slave_pkg;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_e;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} tsize_e;
endpackage

module bus_sram_slave
  import bus_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        breq,
  input  logic        bstart,
  input  ttype_e      ttype,
  input  tsize_e      tsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        bdone
`ifdef BUS_SRAM_SLAVE_BERR_EN
  ,
  output logic        berr
`endif
);
  localparam int unsigned IW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state;
  logic [3:0]  wcnt;
  logic [31:0] lat_addr, lat_wdata;
  ttype_e      lat_ttype;
  tsize_e      lat_tsize;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] acc_addr, acc_wdata, off, mem_word, wsh, rmask;
  ttype_e      acc_ttype;
  tsize_e      acc_tsize;
  logic        start, in_range, aligned, fault, enter_resp, commit;
  logic [IW-1:0] idx;
  logic [3:0]  lanes;

  // With no wait states the access commits on the same edge that samples the
  // request, so in IDLE the live bus is used instead of the latched copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_ttype = lat_ttype;
    acc_tsize = lat_tsize;
    if (state == IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_ttype = ttype;
      acc_tsize = tsize;
    end
  end

  assign start    = breq && bstart;
  assign off      = acc_addr - BASE_ADDR;
  assign in_range = {1'b0, off} < SPAN;
  assign idx      = off[IW+1:2];
  assign mem_word = mem[idx];

  always_comb begin
    aligned = 1'b0;
    lanes   = 4'b0000;
    rmask   = 32'h0000_0000;
    case (acc_tsize)
      BYTE: begin
        aligned = 1'b1;
        lanes   = 4'b0001 << acc_addr[1:0];
        rmask   = 32'h0000_00FF;
      end
      HALF: begin
        aligned = !acc_addr[0];
        lanes   = 4'b0011 << {acc_addr[1], 1'b0};
        rmask   = 32'h0000_FFFF;
      end
      WORD: begin
        aligned = (acc_addr[1:0] == 2'b00);
        lanes   = 4'b1111;
        rmask   = 32'hFFFF_FFFF;
      end
      default: ;
    endcase
  end

  assign fault      = !(in_range && aligned);
  assign wsh        = acc_wdata << {acc_addr[1:0], 3'b000};
  assign enter_resp = ((state == IDLE) && start && (WAIT_STATES == 0)) ||
                      ((state == WAIT) && bstart && (wcnt == 4'd0));
  assign commit     = rst_n && enter_resp && (acc_ttype == WRITE) && !fault;

  // NOTE: storage is deliberately not reset; only control state is, so a reset keeps memory contents.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= 4'd0;
      bdone     <= 1'b0;
      rdata     <= 32'h0000_0000;
      lat_addr  <= 32'h0000_0000;
      lat_wdata <= 32'h0000_0000;
      lat_ttype <= READ;
      lat_tsize <= BYTE;
`ifdef BUS_SRAM_SLAVE_BERR_EN
      berr      <= 1'b0;
`endif
    end else begin
      bdone <= enter_resp;
`ifdef BUS_SRAM_SLAVE_BERR_EN
      berr  <= enter_resp && fault;
`endif
      if (enter_resp) begin
        if (fault) rdata <= 32'h0000_0000;
        else if (acc_ttype == READ) rdata <= (mem_word >> {acc_addr[1:0], 3'b000}) & rmask;
      end
      case (state)
        IDLE: begin
          if (start) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_ttype <= ttype;
            lat_tsize <= tsize;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              wcnt  <= 4'(WAIT_STATES - 1);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!bstart)            state <= IDLE;
          else if (wcnt == 4'd0)  state <= RESP;
          else                    wcnt  <= wcnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench for bus_sram_slave: one instance with no wait states, one with three,
// checked against a byte-array reference model.
`timescale 1ns/1ps
module tb_bus_sram_slave;
  import bus_sram_slave_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0100;
  localparam int          DEPTH = 64;

  typedef struct {
    int          d;
    int          cyc;
    bit          rd;
    logic [31:0] rdata;
    bit          flt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_b [2][DEPTH*4];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        breq_s [2];
  logic        bstart_s [2];
  ttype_e      ttype_s [2];
  tsize_e      tsize_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdata_s [2];
  logic [1:0][31:0] rdata_w;
  logic [1:0]       bdone_w;
`ifdef BUS_SRAM_SLAVE_BERR_EN
  logic [1:0]       berr_w;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .breq(breq_s[0]), .bstart(bstart_s[0]),
    .ttype(ttype_s[0]), .tsize(tsize_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .rdata(rdata_w[0]), .bdone(bdone_w[0])
`ifdef BUS_SRAM_SLAVE_BERR_EN
    , .berr(berr_w[0])
`endif
  );

  bus_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .breq(breq_s[1]), .bstart(bstart_s[1]),
    .ttype(ttype_s[1]), .tsize(tsize_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .rdata(rdata_w[1]), .bdone(bdone_w[1])
`ifdef BUS_SRAM_SLAVE_BERR_EN
    , .berr(berr_w[1])
`endif
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Memory as a flat byte array: an access touches 2**sz consecutive bytes, little-endian.
  function automatic void model(input int d, input bit wr, input int sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output bit flt);
    int n;
    logic [31:0] off;
    n   = 1 << sz;
    off = a - BASE;
    rd  = 32'h0;
    flt = (off >= 32'(DEPTH*4)) || ((a % 32'(n)) != 0);
    if (!flt) begin
      for (int k = 0; k < n; k++) begin
        if (wr) mem_b[d][int'(off) + k] = wd[8*k +: 8];
        else    rd[8*k +: 8] = mem_b[d][int'(off) + k];
      end
    end
  endfunction

  task automatic expect_txn(int d, bit wr, int sz, logic [31:0] a, logic [31:0] wd, int at);
    exp_t e;
    logic [31:0] rd;
    bit flt;
    model(d, wr, sz, a, wd, rd, flt);
    e.d = d; e.cyc = at; e.rd = !wr; e.rdata = rd; e.flt = flt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (bdone_w[d] === 1'b1) begin
        exp_t e;
        done_cnt[d]++;
        check("bdone_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bdone_dut", d, e.d);
          check("bdone_cycle", cyc, e.cyc);
          if (e.rd) check("rdata", rdata_w[d], e.rdata);
`ifdef BUS_SRAM_SLAVE_BERR_EN
          check("berr", 32'(berr_w[d]), 32'(e.flt));
`endif
        end
      end
    end
  end

  task automatic drive(int d, bit wr, int sz, logic [31:0] a, logic [31:0] wd);
    breq_s[d]   = 1'b1;
    bstart_s[d] = 1'b1;
    ttype_s[d]  = ttype_e'(wr);
    tsize_s[d]  = tsize_e'(sz);
    addr_s[d]   = a;
    wdata_s[d]  = wd;
  endtask

  task automatic release_bus(int d);
    breq_s[d]   = 1'b0;
    bstart_s[d] = 1'b0;
  endtask

  task automatic wait_done(int d, int target);
    for (int i = 0; i < 40 && done_cnt[d] < target; i++) begin
      @(negedge clk); #1;
    end
    check("bdone_seen", 32'(done_cnt[d] >= target), 32'd1);
  endtask

  // Called just after a falling edge; the next rising edge samples the request.
  task automatic run_txn(int d, bit wr, int sz, logic [31:0] a, logic [31:0] wd);
    int target;
    target = done_cnt[d] + 1;
    drive(d, wr, sz, a, wd);
    @(posedge clk); #1;
    expect_txn(d, wr, sz, a, wd, cyc + ws_of(d));
    wait_done(d, target);
    release_bus(d);
    @(posedge clk); @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, s;
    for (int d = 0; d < 2; d++) begin
      breq_s[d] = 1'b0; bstart_s[d] = 1'b0; ttype_s[d] = READ; tsize_s[d] = BYTE;
      addr_s[d] = 32'h0; wdata_s[d] = 32'h0; done_cnt[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_bdone", 32'(bdone_w[d]), 32'd0);
      check("reset_rdata", rdata_w[d], 32'h0);
`ifdef BUS_SRAM_SLAVE_BERR_EN
      check("reset_berr", 32'(berr_w[d]), 32'd0);
`endif
    end
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < DEPTH; w++)
        run_txn(d, 1'b1, 2, BASE + 32'(4*w), $urandom);

    for (int d = 0; d < 2; d++) begin
      run_txn(d, 1'b1, 2, BASE + 32'h10, 32'hDEADBEEF);
      run_txn(d, 1'b0, 2, BASE + 32'h10, 32'h0);
      run_txn(d, 1'b1, 0, BASE + 32'h13, 32'h0000_00A5);
      run_txn(d, 1'b0, 2, BASE + 32'h10, 32'h0);
      run_txn(d, 1'b0, 0, BASE + 32'h13, 32'h0);
      run_txn(d, 1'b0, 1, BASE + 32'h12, 32'h0);
      run_txn(d, 1'b1, 2, BASE + 32'h11, 32'h1234_5678);
      run_txn(d, 1'b0, 2, BASE + 32'h10, 32'h0);
      run_txn(d, 1'b0, 2, BASE + 32'(DEPTH*4), 32'h0);
      run_txn(d, 1'b0, 1, BASE + 32'h11, 32'h0);
    end

    // bstart without breq must be ignored
    n = done_cnt[0];
    drive(0, 1'b1, 2, BASE + 32'h18, 32'h5555_AAAA);
    breq_s[0] = 1'b0;
    repeat (5) @(negedge clk); #1;
    check("no_breq_no_bdone", done_cnt[0], n);
    release_bus(0);
    run_txn(0, 1'b0, 2, BASE + 32'h18, 32'h0);

    // Abort: bstart drops in the second wait cycle
    n = done_cnt[1];
    drive(1, 1'b1, 2, BASE + 32'h20, 32'hCAFE_F00D);
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    release_bus(1);
    repeat (8) @(negedge clk); #1;
    check("abort_no_bdone", done_cnt[1], n);
    run_txn(1, 1'b0, 2, BASE + 32'h20, 32'h0);

    // Reset during the wait phase of a write
    n = done_cnt[1];
    drive(1, 1'b1, 2, BASE + 32'h24, 32'h0BAD_F00D);
    @(posedge clk); @(negedge clk); #1;
    rst_n = 1'b0;
    release_bus(1);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_wait_no_bdone", done_cnt[1], n);
    check("rst_wait_rdata0", rdata_w[0], 32'h0);
    check("rst_wait_rdata1", rdata_w[1], 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk); #1;
    check("rst_wait_no_late_bdone", done_cnt[1], n);
    run_txn(1, 1'b0, 2, BASE + 32'h24, 32'h0);

    // Back-to-back: bstart held across bdone, second transaction is a read
    n = done_cnt[0];
    drive(0, 1'b1, 2, BASE + 32'h30, 32'h1357_9BDF);
    @(posedge clk); #1;
    s = cyc;
    expect_txn(0, 1'b1, 2, BASE + 32'h30, 32'h1357_9BDF, s);
    expect_txn(0, 1'b0, 2, BASE + 32'h30, 32'h0, s + 2);
    wait_done(0, n + 1);
    ttype_s[0] = READ;
    wait_done(0, n + 2);
    release_bus(0);
    @(posedge clk); @(negedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      int d, sz, r;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      sz = int'($urandom_range(0, 2));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      a = BASE + 32'(DEPTH*4) + $urandom_range(0, 15);
      else if (r == 1) a = BASE - 32'd1 - $urandom_range(0, 15);
      else             a = BASE + $urandom_range(0, DEPTH*4 - 1);
      run_txn(d, 1'($urandom_range(0, 1)), sz, a, $urandom);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
